// File: rtl/cache_axi_arbiter_pkg.sv
// Shared types for the I/D cache AXI arbiter: FSM states, grant codes, beat sizes.
// Pure definitions; no latency or flow-control behaviour of its own.
package cache_axi_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_I = 2'b01,
    ST_OWN_D = 2'b10
  } arb_state_t;

  localparam logic [1:0] GRANT_IDLE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  function automatic logic [1:0] grant_of(input arb_state_t st);
    case (st)
      ST_OWN_I: grant_of = GRANT_I;
      ST_OWN_D: grant_of = GRANT_D;
      default:  grant_of = GRANT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cache_axi_port_mux.sv
// Combinational steering of the owner's request onto the bus; bus responses reach only the owner.
// Zero latency; the loser sees no handshakes, so it simply stalls until granted.
module cache_axi_port_mux
  import cache_axi_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]              grant,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_addr_valid,
  input  logic                    i_we,
  input  logic [2:0]              i_size,
  input  logic [7:0]              i_lens,
  input  logic                    i_rd_rready,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic                    i_wr_dready,
  input  logic [DATA_WIDTH/8-1:0] i_byte_enable,
  input  logic                    i_wr_last,
  input  logic                    i_response_rready,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic                    d_addr_valid,
  input  logic                    d_we,
  input  logic [2:0]              d_size,
  input  logic [7:0]              d_lens,
  input  logic                    d_rd_rready,
  input  logic [DATA_WIDTH-1:0]   d_wr_data,
  input  logic                    d_wr_dready,
  input  logic [DATA_WIDTH/8-1:0] d_byte_enable,
  input  logic                    d_wr_last,
  input  logic                    d_response_rready,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic                    bus_addr_valid,
  output logic                    bus_we,
  output logic [2:0]              bus_size,
  output logic [7:0]              bus_lens,
  output logic                    bus_rd_rready,
  output logic [DATA_WIDTH-1:0]   bus_wr_data,
  output logic                    bus_wr_dready,
  output logic [DATA_WIDTH/8-1:0] bus_byte_enable,
  output logic                    bus_wr_last,
  output logic                    bus_response_rready,
  input  logic                    bus_rd_dready,
  input  logic                    bus_rd_last,
  input  logic [DATA_WIDTH-1:0]   bus_rd_data,
  input  logic                    bus_rd_addr_clear,
  input  logic                    bus_wr_next,
  input  logic                    bus_wr_ok,
  input  logic                    bus_wr_addr_clear,
  output logic                    i_rd_dready,
  output logic                    i_rd_last,
  output logic [DATA_WIDTH-1:0]   i_rd_data,
  output logic                    i_rd_addr_clear,
  output logic                    i_wr_next,
  output logic                    i_wr_ok,
  output logic                    i_wr_addr_clear,
  output logic                    d_rd_dready,
  output logic                    d_rd_last,
  output logic [DATA_WIDTH-1:0]   d_rd_data,
  output logic                    d_rd_addr_clear,
  output logic                    d_wr_next,
  output logic                    d_wr_ok,
  output logic                    d_wr_addr_clear
);

  logic sel_i;
  logic sel_d;

  assign sel_i = (grant == GRANT_I);
  assign sel_d = (grant == GRANT_D);

  always_comb begin
    bus_addr            = '0;
    bus_addr_valid      = 1'b0;
    bus_we              = 1'b0;
    bus_size            = '0;
    bus_lens            = '0;
    bus_rd_rready       = 1'b0;
    bus_wr_data         = '0;
    bus_wr_dready       = 1'b0;
    bus_byte_enable     = '0;
    bus_wr_last         = 1'b0;
    bus_response_rready = 1'b0;
    if (sel_i) begin
      bus_addr            = i_addr;
      bus_addr_valid      = i_addr_valid;
      bus_we              = i_we;
      bus_size            = i_size;
      bus_lens            = i_lens;
      bus_rd_rready       = i_rd_rready;
      bus_wr_data         = i_wr_data;
      bus_wr_dready       = i_wr_dready;
      bus_byte_enable     = i_byte_enable;
      bus_wr_last         = i_wr_last;
      bus_response_rready = i_response_rready;
    end else if (sel_d) begin
      bus_addr            = d_addr;
      bus_addr_valid      = d_addr_valid;
      bus_we              = d_we;
      bus_size            = d_size;
      bus_lens            = d_lens;
      bus_rd_rready       = d_rd_rready;
      bus_wr_data         = d_wr_data;
      bus_wr_dready       = d_wr_dready;
      bus_byte_enable     = d_byte_enable;
      bus_wr_last         = d_wr_last;
      bus_response_rready = d_response_rready;
    end
  end

  // Read data carries no handshake of its own, so both caches can see it.
  assign i_rd_data       = bus_rd_data;
  assign d_rd_data       = bus_rd_data;

  assign i_rd_dready     = sel_i & bus_rd_dready;
  assign i_rd_last       = sel_i & bus_rd_last;
  assign i_rd_addr_clear = sel_i & bus_rd_addr_clear;
  assign i_wr_next       = sel_i & bus_wr_next;
  assign i_wr_ok         = sel_i & bus_wr_ok;
  assign i_wr_addr_clear = sel_i & bus_wr_addr_clear;

  assign d_rd_dready     = sel_d & bus_rd_dready;
  assign d_rd_last       = sel_d & bus_rd_last;
  assign d_rd_addr_clear = sel_d & bus_rd_addr_clear;
  assign d_wr_next       = sel_d & bus_wr_next;
  assign d_wr_ok         = sel_d & bus_wr_ok;
  assign d_wr_addr_clear = sel_d & bus_wr_addr_clear;

endmodule

// File: rtl/cache_axi_arbiter.sv
// Per-transaction arbiter of one cache AXI port between I and D caches; grant 1 cycle after request, >=1 idle cycle between owners.
// Loser is stalled by masked handshakes; CACHE_ARB_RR_EN selects round-robin, else D has fixed priority.
module cache_axi_arbiter
  import cache_axi_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_addr_valid,
  input  logic                    i_we,
  input  logic [2:0]              i_size,
  input  logic [7:0]              i_lens,
  input  logic                    i_rd_rready,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic                    i_wr_dready,
  input  logic [DATA_WIDTH/8-1:0] i_byte_enable,
  input  logic                    i_wr_last,
  input  logic                    i_response_rready,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic                    d_addr_valid,
  input  logic                    d_we,
  input  logic [2:0]              d_size,
  input  logic [7:0]              d_lens,
  input  logic                    d_rd_rready,
  input  logic [DATA_WIDTH-1:0]   d_wr_data,
  input  logic                    d_wr_dready,
  input  logic [DATA_WIDTH/8-1:0] d_byte_enable,
  input  logic                    d_wr_last,
  input  logic                    d_response_rready,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic                    bus_addr_valid,
  output logic                    bus_we,
  output logic [2:0]              bus_size,
  output logic [7:0]              bus_lens,
  output logic                    bus_rd_rready,
  output logic [DATA_WIDTH-1:0]   bus_wr_data,
  output logic                    bus_wr_dready,
  output logic [DATA_WIDTH/8-1:0] bus_byte_enable,
  output logic                    bus_wr_last,
  output logic                    bus_response_rready,
  input  logic                    bus_rd_dready,
  input  logic                    bus_rd_last,
  input  logic [DATA_WIDTH-1:0]   bus_rd_data,
  input  logic                    bus_rd_addr_clear,
  input  logic                    bus_wr_next,
  input  logic                    bus_wr_ok,
  input  logic                    bus_wr_addr_clear,
  output logic                    i_rd_dready,
  output logic                    i_rd_last,
  output logic [DATA_WIDTH-1:0]   i_rd_data,
  output logic                    i_rd_addr_clear,
  output logic                    i_wr_next,
  output logic                    i_wr_ok,
  output logic                    i_wr_addr_clear,
  output logic                    d_rd_dready,
  output logic                    d_rd_last,
  output logic [DATA_WIDTH-1:0]   d_rd_data,
  output logic                    d_rd_addr_clear,
  output logic                    d_wr_next,
  output logic                    d_wr_ok,
  output logic                    d_wr_addr_clear,
  output logic [1:0]              grant
);

  arb_state_t state;
  logic       owner_we;
  logic       win_i;
  logic       win_d;
  logic       txn_done;

`ifdef CACHE_ARB_RR_EN
  logic last_owner_d;  // 0 = I served last, 1 = D served last

  assign win_d = d_addr_valid & (~i_addr_valid | ~last_owner_d);
`else
  assign win_d = d_addr_valid;
`endif
  assign win_i = i_addr_valid & ~win_d;

  // End detection keys off the direction latched at grant, not the live we.
  assign txn_done = owner_we ? (bus_wr_ok & bus_response_rready)
                             : (bus_rd_dready & bus_rd_last & bus_rd_rready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      grant    <= GRANT_IDLE;
      owner_we <= 1'b0;
`ifdef CACHE_ARB_RR_EN
      last_owner_d <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_d) begin
            state    <= ST_OWN_D;
            grant    <= grant_of(ST_OWN_D);
            owner_we <= d_we;
`ifdef CACHE_ARB_RR_EN
            last_owner_d <= 1'b1;
`endif
          end else if (win_i) begin
            state    <= ST_OWN_I;
            grant    <= grant_of(ST_OWN_I);
            owner_we <= i_we;
`ifdef CACHE_ARB_RR_EN
            last_owner_d <= 1'b0;
`endif
          end
        end
        ST_OWN_I, ST_OWN_D: begin
          if (txn_done) begin
            state <= ST_IDLE;
            grant <= GRANT_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= GRANT_IDLE;
        end
      endcase
    end
  end

  cache_axi_port_mux #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_port_mux (
    .grant               (grant),
    .i_addr              (i_addr),
    .i_addr_valid        (i_addr_valid),
    .i_we                (i_we),
    .i_size              (i_size),
    .i_lens              (i_lens),
    .i_rd_rready         (i_rd_rready),
    .i_wr_data           (i_wr_data),
    .i_wr_dready         (i_wr_dready),
    .i_byte_enable       (i_byte_enable),
    .i_wr_last           (i_wr_last),
    .i_response_rready   (i_response_rready),
    .d_addr              (d_addr),
    .d_addr_valid        (d_addr_valid),
    .d_we                (d_we),
    .d_size              (d_size),
    .d_lens              (d_lens),
    .d_rd_rready         (d_rd_rready),
    .d_wr_data           (d_wr_data),
    .d_wr_dready         (d_wr_dready),
    .d_byte_enable       (d_byte_enable),
    .d_wr_last           (d_wr_last),
    .d_response_rready   (d_response_rready),
    .bus_addr            (bus_addr),
    .bus_addr_valid      (bus_addr_valid),
    .bus_we              (bus_we),
    .bus_size            (bus_size),
    .bus_lens            (bus_lens),
    .bus_rd_rready       (bus_rd_rready),
    .bus_wr_data         (bus_wr_data),
    .bus_wr_dready       (bus_wr_dready),
    .bus_byte_enable     (bus_byte_enable),
    .bus_wr_last         (bus_wr_last),
    .bus_response_rready (bus_response_rready),
    .bus_rd_dready       (bus_rd_dready),
    .bus_rd_last         (bus_rd_last),
    .bus_rd_data         (bus_rd_data),
    .bus_rd_addr_clear   (bus_rd_addr_clear),
    .bus_wr_next         (bus_wr_next),
    .bus_wr_ok           (bus_wr_ok),
    .bus_wr_addr_clear   (bus_wr_addr_clear),
    .i_rd_dready         (i_rd_dready),
    .i_rd_last           (i_rd_last),
    .i_rd_data           (i_rd_data),
    .i_rd_addr_clear     (i_rd_addr_clear),
    .i_wr_next           (i_wr_next),
    .i_wr_ok             (i_wr_ok),
    .i_wr_addr_clear     (i_wr_addr_clear),
    .d_rd_dready         (d_rd_dready),
    .d_rd_last           (d_rd_last),
    .d_rd_data           (d_rd_data),
    .d_rd_addr_clear     (d_rd_addr_clear),
    .d_wr_next           (d_wr_next),
    .d_wr_ok             (d_wr_ok),
    .d_wr_addr_clear     (d_wr_addr_clear)
  );

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Bench for cache_axi_arbiter: directed scenarios plus random traffic against an ownership model.
// The bench plays both caches and the bridge; honours CACHE_ARB_RR_EN when defined.
module tb_cache_axi_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] i_addr, d_addr, bus_addr;
  logic i_addr_valid, d_addr_valid, bus_addr_valid;
  logic i_we, d_we, bus_we;
  logic [2:0] i_size, d_size, bus_size;
  logic [7:0] i_lens, d_lens, bus_lens;
  logic i_rd_rready, d_rd_rready, bus_rd_rready;
  logic [DW-1:0] i_wr_data, d_wr_data, bus_wr_data;
  logic i_wr_dready, d_wr_dready, bus_wr_dready;
  logic [DW/8-1:0] i_byte_enable, d_byte_enable, bus_byte_enable;
  logic i_wr_last, d_wr_last, bus_wr_last;
  logic i_response_rready, d_response_rready, bus_response_rready;
  logic bus_rd_dready, bus_rd_last, bus_rd_addr_clear, bus_wr_next, bus_wr_ok, bus_wr_addr_clear;
  logic [DW-1:0] bus_rd_data, i_rd_data, d_rd_data;
  logic i_rd_dready, i_rd_last, i_rd_addr_clear, i_wr_next, i_wr_ok, i_wr_addr_clear;
  logic d_rd_dready, d_rd_last, d_rd_addr_clear, d_wr_next, d_wr_ok, d_wr_addr_clear;
  logic [1:0] grant;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the bus (0 none, 1 I, 2 D), direction of the
  // running transaction, and who was served last (1 I, 2 D).
  int   m_owner = 0;
  logic m_we = 1'b0;
  int   m_last = 1;

  int cnt_i_beats, cnt_d_beats, cnt_i_wrx, cnt_d_clear;

  cache_axi_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_addr_valid(i_addr_valid), .i_we(i_we), .i_size(i_size), .i_lens(i_lens),
    .i_rd_rready(i_rd_rready), .i_wr_data(i_wr_data), .i_wr_dready(i_wr_dready),
    .i_byte_enable(i_byte_enable), .i_wr_last(i_wr_last), .i_response_rready(i_response_rready),
    .d_addr(d_addr), .d_addr_valid(d_addr_valid), .d_we(d_we), .d_size(d_size), .d_lens(d_lens),
    .d_rd_rready(d_rd_rready), .d_wr_data(d_wr_data), .d_wr_dready(d_wr_dready),
    .d_byte_enable(d_byte_enable), .d_wr_last(d_wr_last), .d_response_rready(d_response_rready),
    .bus_addr(bus_addr), .bus_addr_valid(bus_addr_valid), .bus_we(bus_we), .bus_size(bus_size),
    .bus_lens(bus_lens), .bus_rd_rready(bus_rd_rready), .bus_wr_data(bus_wr_data),
    .bus_wr_dready(bus_wr_dready), .bus_byte_enable(bus_byte_enable), .bus_wr_last(bus_wr_last),
    .bus_response_rready(bus_response_rready),
    .bus_rd_dready(bus_rd_dready), .bus_rd_last(bus_rd_last), .bus_rd_data(bus_rd_data),
    .bus_rd_addr_clear(bus_rd_addr_clear), .bus_wr_next(bus_wr_next), .bus_wr_ok(bus_wr_ok),
    .bus_wr_addr_clear(bus_wr_addr_clear),
    .i_rd_dready(i_rd_dready), .i_rd_last(i_rd_last), .i_rd_data(i_rd_data),
    .i_rd_addr_clear(i_rd_addr_clear), .i_wr_next(i_wr_next), .i_wr_ok(i_wr_ok),
    .i_wr_addr_clear(i_wr_addr_clear),
    .d_rd_dready(d_rd_dready), .d_rd_last(d_rd_last), .d_rd_data(d_rd_data),
    .d_rd_addr_clear(d_rd_addr_clear), .d_wr_next(d_wr_next), .d_wr_ok(d_wr_ok),
    .d_wr_addr_clear(d_wr_addr_clear),
    .grant(grant)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner of an idle-cycle request.
  function automatic int pick(input logic iv, input logic dv, input int last);
    if (iv && dv) begin
`ifdef CACHE_ARB_RR_EN
      return (last == 2) ? 1 : 2;
`else
      return 2;
`endif
    end
    if (dv) return 2;
    if (iv) return 1;
    return 0;
  endfunction

  task automatic check_outputs();
    logic [84:0] ireq, dreq, ereq, oreq;
    logic [5:0]  bresp, iresp, dresp;
    logic [1:0]  eg;
    ireq = {i_addr, i_addr_valid, i_we, i_size, i_lens, i_rd_rready, i_wr_data,
            i_wr_dready, i_byte_enable, i_wr_last, i_response_rready};
    dreq = {d_addr, d_addr_valid, d_we, d_size, d_lens, d_rd_rready, d_wr_data,
            d_wr_dready, d_byte_enable, d_wr_last, d_response_rready};
    oreq = {bus_addr, bus_addr_valid, bus_we, bus_size, bus_lens, bus_rd_rready, bus_wr_data,
            bus_wr_dready, bus_byte_enable, bus_wr_last, bus_response_rready};
    ereq = (m_owner == 1) ? ireq : (m_owner == 2) ? dreq : '0;
    eg   = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    bresp = {bus_rd_dready, bus_rd_last, bus_rd_addr_clear, bus_wr_next, bus_wr_ok, bus_wr_addr_clear};
    iresp = {i_rd_dready, i_rd_last, i_rd_addr_clear, i_wr_next, i_wr_ok, i_wr_addr_clear};
    dresp = {d_rd_dready, d_rd_last, d_rd_addr_clear, d_wr_next, d_wr_ok, d_wr_addr_clear};
    chk("grant", 128'(grant), 128'(eg));
    chk("bus_req", 128'(oreq), 128'(ereq));
    chk("i_resp", 128'(iresp), 128'((m_owner == 1) ? bresp : 6'd0));
    chk("d_resp", 128'(dresp), 128'((m_owner == 2) ? bresp : 6'd0));
    chk("i_rd_data", 128'(i_rd_data), 128'(bus_rd_data));
    chk("d_rd_data", 128'(d_rd_data), 128'(bus_rd_data));
  endtask

  task automatic model_step();
    int   w;
    logic rr, rsp;
    if (!rst) begin
      m_owner = 0;
      m_last  = 1;
    end else if (m_owner == 0) begin
      w = pick(i_addr_valid, d_addr_valid, m_last);
      if (w != 0) begin
        m_owner = w;
        m_we    = (w == 1) ? i_we : d_we;
        m_last  = w;
      end
    end else begin
      rr  = (m_owner == 1) ? i_rd_rready : d_rd_rready;
      rsp = (m_owner == 1) ? i_response_rready : d_response_rready;
      if (m_we ? (bus_wr_ok && rsp) : (bus_rd_dready && bus_rd_last && rr))
        m_owner = 0;
    end
  endtask

  // One clock: check at negedge, advance model, return 1 time unit after posedge.
  task automatic cyc();
    @(negedge clk);
    check_outputs();
    cnt_i_beats += int'(i_rd_dready);
    cnt_d_beats += int'(d_rd_dready);
    cnt_i_wrx   += int'(i_wr_next | i_wr_ok);
    cnt_d_clear += int'(d_rd_addr_clear | d_wr_addr_clear);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_addr = '0; i_addr_valid = 0; i_we = 0; i_size = '0; i_lens = '0; i_rd_rready = 0;
    i_wr_data = '0; i_wr_dready = 0; i_byte_enable = '0; i_wr_last = 0; i_response_rready = 0;
    d_addr = '0; d_addr_valid = 0; d_we = 0; d_size = '0; d_lens = '0; d_rd_rready = 0;
    d_wr_data = '0; d_wr_dready = 0; d_byte_enable = '0; d_wr_last = 0; d_response_rready = 0;
    bus_rd_dready = 0; bus_rd_last = 0; bus_rd_data = '0; bus_rd_addr_clear = 0;
    bus_wr_next = 0; bus_wr_ok = 0; bus_wr_addr_clear = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_exp [4];
    int k, guard;
`ifdef CACHE_ARB_RR_EN
    rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    rr_exp = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    cnt_i_beats = 0; cnt_d_beats = 0; cnt_i_wrx = 0; cnt_d_clear = 0;
    clear_inputs();
    i_addr_valid = 1; d_addr_valid = 1;  // requests during reset must be ignored
    cyc();
    cyc();
    chk("rst_grant", 128'(grant), 128'(2'b00));
    chk("rst_bus_av", 128'(bus_addr_valid), 128'(1'b0));
    clear_inputs();
    rst = 1'b1;
    cyc();

    // Lone I read of 16 beats with bridge stalls.
    i_addr = $urandom; i_addr_valid = 1; i_lens = 8'd15; i_size = 3'd2; i_rd_rready = 1;
    cyc();
    chk("t1_grant", 128'(grant), 128'(2'b01));
    chk("t1_bus_av", 128'(bus_addr_valid), 128'(1'b1));
    bus_rd_addr_clear = 1;
    cyc();
    bus_rd_addr_clear = 0; i_addr_valid = 0;
    cnt_i_beats = 0; cnt_d_beats = 0;
    k = 0; guard = 0;
    while (k < 16 && guard < 100) begin
      bus_rd_dready = ($urandom_range(0, 3) != 0);
      bus_rd_data   = $urandom;
      bus_rd_last   = bus_rd_dready && (k == 15);
      if (bus_rd_dready) k++;
      cyc();
      guard++;
    end
    chk("t1_idle", 128'(grant), 128'(2'b00));
    chk("t1_i_beats", 128'(cnt_i_beats), 128'(16));
    chk("t1_d_beats", 128'(cnt_d_beats), 128'(0));
    clear_inputs();

    // Simultaneous I read and D write (4 beats): D goes first, I after the ack.
    i_addr = $urandom; i_addr_valid = 1; i_rd_rready = 1;
    d_addr = $urandom; d_addr_valid = 1; d_we = 1; d_lens = 8'd3;
    cyc();
    chk("t2_first", 128'(grant), 128'(2'b10));
    bus_wr_addr_clear = 1;
    cyc();
    bus_wr_addr_clear = 0; d_addr_valid = 0; cnt_i_wrx = 0;
    for (int b = 0; b < 4; b++) begin
      d_wr_dready = 1; d_wr_data = $urandom; d_byte_enable = 4'hf; d_wr_last = (b == 3);
      bus_wr_next = 1;
      cyc();
    end
    d_wr_dready = 0; d_wr_last = 0; bus_wr_next = 0; bus_wr_ok = 1;
    cyc();
    chk("t2_hold", 128'(grant), 128'(2'b10));
    d_response_rready = 1;
    cyc();
    chk("t2_gap", 128'(grant), 128'(2'b00));
    bus_wr_ok = 0; d_response_rready = 0;
    cyc();
    chk("t2_second", 128'(grant), 128'(2'b01));
    chk("t2_i_wr_leak", 128'(cnt_i_wrx), 128'(0));
    bus_rd_addr_clear = 1;
    cyc();
    bus_rd_addr_clear = 0; i_addr_valid = 0; bus_rd_dready = 1; bus_rd_last = 1;
    cyc();
    chk("t2_done", 128'(grant), 128'(2'b00));
    clear_inputs();

    // Four simultaneous single-beat reads back to back.
    i_addr = $urandom; d_addr = $urandom; i_addr_valid = 1; d_addr_valid = 1;
    i_rd_rready = 1; d_rd_rready = 1;
    for (int r = 0; r < 4; r++) begin
      cyc();
      chk("rr_grant", 128'(grant), 128'(rr_exp[r]));
      bus_rd_dready = 1; bus_rd_last = 1;
      cyc();
      bus_rd_dready = 0; bus_rd_last = 0;
    end
    clear_inputs();

    // Async reset on the third beat of an 8-beat D read.
    d_addr = $urandom; d_addr_valid = 1; d_lens = 8'd7; d_rd_rready = 1;
    cyc();
    bus_rd_addr_clear = 1;
    cyc();
    bus_rd_addr_clear = 0; d_addr_valid = 0; bus_rd_dready = 1;
    cyc();
    cyc();
    rst = 1'b0;
    m_owner = 0; m_last = 1;
    #1;
    chk("t4_grant", 128'(grant), 128'(2'b00));
    chk("t4_bus_av", 128'(bus_addr_valid), 128'(1'b0));
    chk("t4_bus_rr", 128'(bus_rd_rready), 128'(1'b0));
    chk("t4_d_rd", 128'(d_rd_dready), 128'(1'b0));
    cyc();
    clear_inputs();
    rst = 1'b1;
    cyc();
    chk("t4_idle", 128'(grant), 128'(2'b00));

    // D requests while I's write waits for its ack.
    i_addr = $urandom; i_addr_valid = 1; i_we = 1; i_response_rready = 1;
    cyc();
    chk("t5_i", 128'(grant), 128'(2'b01));
    bus_wr_addr_clear = 1;
    cyc();
    i_addr_valid = 0; d_addr = $urandom; d_addr_valid = 1; d_rd_rready = 1;
    bus_rd_addr_clear = 1; cnt_d_clear = 0;
    for (int b = 0; b < 3; b++) begin
      i_wr_dready = 1; i_wr_data = $urandom; i_wr_last = (b == 2); bus_wr_next = 1;
      cyc();
    end
    i_wr_dready = 0; i_wr_last = 0; bus_wr_next = 0;
    bus_rd_addr_clear = 0; bus_wr_addr_clear = 0;
    chk("t5_d_clear", 128'(cnt_d_clear), 128'(0));
    bus_wr_ok = 1;
    cyc();
    chk("t5_gap", 128'(grant), 128'(2'b00));
    bus_wr_ok = 0;
    cyc();
    chk("t5_d", 128'(grant), 128'(2'b10));
    chk("t5_addr", 128'(bus_addr), 128'(d_addr));
    d_addr_valid = 0; bus_rd_dready = 1; bus_rd_last = 1;
    cyc();
    clear_inputs();

    // Random traffic, including mid-transaction we flips and early addr_valid drops.
    for (int n = 0; n < 400; n++) begin
      i_addr = $urandom; d_addr = $urandom;
      i_addr_valid = ($urandom_range(0, 2) != 0); d_addr_valid = ($urandom_range(0, 2) != 0);
      i_we = 1'($urandom); d_we = 1'($urandom);
      i_size = 3'($urandom); d_size = 3'($urandom);
      i_lens = 8'($urandom); d_lens = 8'($urandom);
      i_rd_rready = 1'($urandom); d_rd_rready = 1'($urandom);
      i_wr_data = $urandom; d_wr_data = $urandom;
      i_wr_dready = 1'($urandom); d_wr_dready = 1'($urandom);
      i_byte_enable = 4'($urandom); d_byte_enable = 4'($urandom);
      i_wr_last = 1'($urandom); d_wr_last = 1'($urandom);
      i_response_rready = 1'($urandom); d_response_rready = 1'($urandom);
      bus_rd_dready = 1'($urandom); bus_rd_last = ($urandom_range(0, 3) == 0);
      bus_rd_data = $urandom; bus_rd_addr_clear = 1'($urandom);
      bus_wr_next = 1'($urandom); bus_wr_ok = ($urandom_range(0, 3) == 0);
      bus_wr_addr_clear = 1'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
